// File: rtl/mac_array_cfg.sv
// Systolic MAC array: host instructions ripple one column per cycle; each column
// holds its own weight vector and emits one dot product per execute.
module mac_array_cfg #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int pr      = 8,
    parameter int bw_psum = 2*bw+3   // must be >= 2*bw + clog2(pr)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [pr*bw-1:0]       in,
    input  logic [1:0]             inst,
    input  logic                   sgn,
    input  logic [col-1:0]         col_en,
    output logic [bw_psum*col-1:0] out,
    output logic [col-1:0]         fifo_wr
);

    localparam logic [1:0] INST_LOAD  = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;
    localparam logic [1:0] INST_CLEAR = 2'b11;
    localparam int         CW         = $clog2(col+1);
    localparam int         PW         = 2*bw+2;

    // One extra bit per operand lets signed and unsigned share one signed multiplier.
    function automatic logic signed [PW-1:0] lane_prod(
        input logic [bw-1:0] a,
        input logic [bw-1:0] b,
        input logic          s
    );
        logic signed [bw:0] ae;
        logic signed [bw:0] be;
        ae = {s & a[bw-1], a};
        be = {s & b[bw-1], b};
        return PW'(ae) * PW'(be);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_col
            logic [pr*bw-1:0]   w_in;
            logic [1:0]         w_inst;
            logic               w_sgn;
            logic [col-1:gi]    w_en;     // only this column's bit and those downstream travel on
            logic [pr*bw-1:0]   r_w;
            logic [CW-1:0]      r_cnt;
            logic [bw_psum-1:0] r_out;
            logic               r_wr;
            logic [bw_psum-1:0] w_acc;

            if (gi == 0) begin : g_head
                assign w_in   = in;
                assign w_inst = inst;
                assign w_sgn  = sgn;
                assign w_en   = col_en;
            end else begin : g_link
                logic [pr*bw-1:0] r_in;
                logic [1:0]       r_inst;
                logic             r_sgn;
                logic [col-1:gi]  r_en;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_in   <= '0;
                        r_inst <= '0;
                        r_sgn  <= 1'b0;
                        r_en   <= '0;
                    end else begin
                        r_in   <= g_col[gi-1].w_in;
                        r_inst <= g_col[gi-1].w_inst;
                        r_sgn  <= g_col[gi-1].w_sgn;
                        r_en   <= g_col[gi-1].w_en[col-1:gi];
                    end
                end

                assign w_in   = r_in;
                assign w_inst = r_inst;
                assign w_sgn  = r_sgn;
                assign w_en   = r_en;
            end

            // Truncating/extending each product to bw_psum keeps the sum exact modulo 2^bw_psum.
            always_comb begin
                w_acc = '0;
                for (int p = 0; p < pr; p++) begin
                    w_acc = w_acc + bw_psum'(lane_prod(w_in[bw*p +: bw], r_w[bw*p +: bw], w_sgn));
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_w   <= '0;
                    r_cnt <= '0;
                    r_out <= '0;
                    r_wr  <= 1'b0;
                end else begin
                    r_wr <= 1'b0;
                    case (w_inst)
                        INST_LOAD: begin
                            // The k-th load after a clear is the one addressed to column k.
                            if (r_cnt == CW'(gi)) begin
                                r_w <= w_in;
                            end
                            if (r_cnt != CW'(col)) begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                        INST_EXEC: begin
                            if (w_en[gi]) begin
                                r_out <= w_acc;
                                r_wr  <= 1'b1;
                            end
                        end
                        INST_CLEAR: begin
                            r_w   <= '0;
                            r_cnt <= '0;
                        end
                        default: ;
                    endcase
                end
            end

            assign out[bw_psum*gi +: bw_psum] = r_out;
            assign fifo_wr[gi]                = r_wr;
        end
    endgenerate

endmodule

// File: tb/tb_mac_array_cfg.sv
// Directed bench for mac_array_cfg: a weight/result model fills a scoreboard at
// issue time; a negedge monitor checks strobe timing and result values.
module tb_mac_array_cfg;

    localparam int COL = 8;
    localparam int BW  = 8;
    localparam int PR  = 8;
    localparam int BWP = 19;
    localparam logic [1:0] LD = 2'b01;
    localparam logic [1:0] EX = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    logic             clk = 1'b0;
    logic             reset;
    logic [PR*BW-1:0] in;
    logic [1:0]       inst;
    logic             sgn;
    logic [COL-1:0]   col_en;
    logic [BWP*COL-1:0] out;
    logic [COL-1:0]   fifo_wr;

    mac_array_cfg #(.col(COL), .bw(BW), .pr(PR), .bw_psum(BWP)) dut (
        .clk(clk), .reset(reset), .in(in), .inst(inst), .sgn(sgn),
        .col_en(col_en), .out(out), .fifo_wr(fifo_wr)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          col;
        int          due;
        logic [18:0] val;
    } exp_t;
    exp_t sb[$];

    logic [7:0]  wm [COL][PR];
    int          cnt_m [COL];
    logic [18:0] last_out [COL];

    function automatic logic [63:0] splat(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [18:0] mac(input logic [63:0] v, input int k, input logic s);
        int acc;
        int a;
        int b;
        acc = 0;
        for (int p = 0; p < PR; p++) begin
            a = s ? int'(signed'(v[8*p +: 8])) : int'(v[8*p +: 8]);
            b = s ? int'(signed'(wm[k][p])) : int'(wm[k][p]);
            acc += a * b;
        end
        return acc[18:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < COL; k++) begin
            cnt_m[k] = 0;
            last_out[k] = '0;
            for (int p = 0; p < PR; p++) wm[k][p] = '0;
        end
    endtask

    task automatic issue(input logic [1:0] i, input logic [63:0] v, input logic s, input logic [7:0] en);
        logic [18:0] val;
        in = v; inst = i; sgn = s; col_en = en;
        case (i)
            LD: for (int k = 0; k < COL; k++) begin
                if (cnt_m[k] == k) for (int p = 0; p < PR; p++) wm[k][p] = v[8*p +: 8];
                if (cnt_m[k] < COL) cnt_m[k]++;
            end
            CL: for (int k = 0; k < COL; k++) begin
                cnt_m[k] = 0;
                for (int p = 0; p < PR; p++) wm[k][p] = '0;
            end
            EX: for (int k = 0; k < COL; k++) begin
                if (en[k]) begin
                    val = mac(v, k, s);
                    last_out[k] = val;
                    sb.push_back('{col: k, due: cycle + k + 1, val: val});
                end
            end
            default: ;
        endcase
        @(posedge clk); #1;
        inst = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_hold(input string tag);
        for (int k = 0; k < COL; k++) begin
            compared++;
            assert (out[BWP*k +: BWP] === last_out[k]) else begin
                mismatched++;
                $error("FAIL %s col%0d observed=%0d expected=%0d", tag, k, out[BWP*k +: BWP], last_out[k]);
            end
        end
    endtask

    task automatic expect_all(input logic [18:0] v, input string tag);
        for (int k = 0; k < COL; k++) begin
            compared++;
            assert (out[BWP*k +: BWP] === v) else begin
                mismatched++;
                $error("FAIL %s col%0d observed=%0d expected=%0d", tag, k, out[BWP*k +: BWP], v);
            end
        end
    endtask

    // Strobe pattern must match exactly the results due this cycle; each due result is then checked.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            logic [7:0] exp_wr;
            exp_wr = '0;
            for (int e = 0; e < sb.size(); e++) if (sb[e].due == cycle) exp_wr[sb[e].col] = 1'b1;
            compared++;
            assert (fifo_wr === exp_wr) else begin
                mismatched++;
                $error("FAIL fifo_wr cycle%0d observed=%b expected=%b", cycle, fifo_wr, exp_wr);
            end
            for (int e = sb.size() - 1; e >= 0; e--) begin
                if (sb[e].due == cycle) begin
                    compared++;
                    assert (out[BWP*sb[e].col +: BWP] === sb[e].val) else begin
                        mismatched++;
                        $error("FAIL result col%0d cycle%0d observed=%0d expected=%0d",
                               sb[e].col, cycle, out[BWP*sb[e].col +: BWP], sb[e].val);
                    end
                    sb.delete(e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in = '0; inst = 2'b00; sgn = 1'b0; col_en = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        assert (out === '0) else begin
            mismatched++; $error("FAIL reset_out observed=%h expected=0", out);
        end
        compared++;
        assert (fifo_wr === 8'h00) else begin
            mismatched++; $error("FAIL reset_fifo_wr observed=%b expected=0", fifo_wr);
        end
        reset = 1'b0;

        // basic load + unsigned execute; the ninth load must be ignored
        for (int j = 0; j < COL; j++) issue(LD, splat(8'(j + 1)), 1'b0, 8'h00);
        issue(LD, splat(8'h77), 1'b0, 8'h00);
        issue(EX, splat(8'h01), 1'b0, 8'hFF);
        idle(10);
        for (int k = 0; k < COL; k++) begin
            compared++;
            assert (out[BWP*k +: BWP] === 19'(8 * (k + 1))) else begin
                mismatched++;
                $error("FAIL basic col%0d observed=%0d expected=%0d", k, out[BWP*k +: BWP], 8 * (k + 1));
            end
        end

        // signed and unsigned extremes
        issue(CL, '0, 1'b0, 8'h00);
        for (int j = 0; j < COL; j++) issue(LD, splat(8'h80), 1'b0, 8'h00);
        issue(EX, splat(8'h80), 1'b1, 8'hFF);
        idle(10);
        expect_all(19'd131072, "signed_min");
        issue(CL, '0, 1'b0, 8'h00);
        for (int j = 0; j < COL; j++) issue(LD, splat(8'hFF), 1'b0, 8'h00);
        issue(EX, splat(8'hFF), 1'b0, 8'hFF);
        idle(10);
        expect_all(19'd520200, "unsigned_max");

        // column mask: even columns keep 520200
        issue(EX, splat(8'h01), 1'b0, 8'b1010_1010);
        idle(10);
        check_hold("mask_hold");

        // clear and partial reload
        issue(CL, '0, 1'b0, 8'h00);
        for (int j = 0; j < 3; j++) issue(LD, splat(8'h02), 1'b0, 8'h00);
        issue(EX, splat(8'h01), 1'b0, 8'hFF);
        idle(10);
        check_hold("clear_reload");

        // streaming executes back to back
        for (int v = 1; v <= 4; v++) issue(EX, splat(8'(v)), 1'b0, 8'hFF);
        idle(12);
        check_hold("stream_last");

        // mixed load/execute stream
        issue(CL, '0, 1'b0, 8'h00);
        issue(LD, splat(8'h03), 1'b0, 8'h00);
        issue(EX, splat(8'h01), 1'b0, 8'hFF);
        issue(LD, splat(8'h05), 1'b0, 8'h00);
        issue(EX, splat(8'h02), 1'b1, 8'hFF);
        idle(12);
        check_hold("mixed");

        // random weights and executes
        issue(CL, '0, 1'b0, 8'h00);
        for (int j = 0; j < COL; j++) issue(LD, {$urandom, $urandom}, 1'b0, 8'h00);
        for (int j = 0; j < 8; j++) issue(EX, {$urandom, $urandom}, 1'($urandom_range(1)), 8'($urandom));
        idle(12);
        check_hold("random");

        // reset in the middle of an execute wave
        issue(EX, splat(8'h01), 1'b0, 8'hFF);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        compared++;
        assert (out === '0) else begin
            mismatched++; $error("FAIL midreset_out observed=%h expected=0", out);
        end
        compared++;
        assert (fifo_wr === 8'h00) else begin
            mismatched++; $error("FAIL midreset_fifo_wr observed=%b expected=0", fifo_wr);
        end
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(12);
        issue(EX, splat(8'h01), 1'b0, 8'hFF);
        idle(10);
        expect_all(19'd0, "post_reset_exec");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mac_array_cfg.md
MAC_ARRAY_CFG -- requirements
Module: mac_array_cfg

Interface
REQ-001 SHALL have parameter col, default 8: number of MAC columns.
REQ-002 SHALL have parameter bw, default 8: operand width.
REQ-003 SHALL have parameter pr, default 8: lanes (products) per column.
REQ-004 SHALL have parameter bw_psum, default 2*bw+3: result width; legal only if bw_psum >= 2*bw+clog2(pr).
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in, input, pr*bw: lane vector; lane p at [bw*(p+1)-1 : bw*p].
REQ-008 SHALL have port inst, input, 2: 2'b01 load, 2'b10 execute, 2'b11 weight clear, 2'b00 idle.
REQ-009 SHALL have port sgn, input, 1: 1 = signed two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port col_en, input, col: per-column result-write enable.
REQ-011 SHALL have port out, output, bw_psum*col: column k result at [bw_psum*(k+1)-1 : bw_psum*k].
REQ-012 SHALL have port fifo_wr, output, col: column k result-valid strobe.

Function
REQ-013 SHALL propagate {in, inst, sgn, col_en[k]} through the columns as a systolic chain: column k sees the host values delayed by k cycles; column 0 sees them undelayed.
REQ-014 SHALL give each column k a pr*bw weight register and a load counter 0..col, saturating at col.
REQ-015 On load at column k: counter == k captures the vector into weights; counter increments (saturating) on every load.
REQ-016 SHALL make col back-to-back loads leave vector j in column j; loads beyond col are ignored.
REQ-017 On weight clear at column k: weights and load counter go to 0 next cycle; no fifo_wr.
REQ-018 On execute at column k with its col_en bit = 1: out_k <= sum over p of in[p]*w[p], and fifo_wr[k] = 1 for exactly that one cycle.
REQ-019 SHALL make execute latency k+1 cycles from host issue to out_k/fifo_wr[k] valid.
REQ-020 SHALL sign-extend operands, products and sum when sgn = 1; otherwise zero-extend; the result is written into bw_psum bits without saturation.
REQ-021 SHALL treat execute with col_en bit = 0 as masked: out_k holds, fifo_wr[k] = 0, chain forwarding continues.
REQ-022 SHALL use the current weights (zero if never loaded) when execute reaches a not-yet-loaded column; fifo_wr still pulses.
REQ-023 SHALL accept back-to-back executes at one result per column per cycle with no bubbles.
REQ-024 SHALL handle mixed streams (load followed next cycle by execute) per column in arrival order, with no hazard.
REQ-025 On idle or masked execute: out holds its value and fifo_wr = 0.

Reset
REQ-026 Reset SHALL asynchronously clear all chain registers, weights, load counters, out (all 0) and fifo_wr (all 0).
REQ-027 Reset asserted mid-stream SHALL discard in-flight instructions: no fifo_wr pulse from any pre-reset instruction after release.
REQ-028 After release, SHALL ignore inst until the first rising edge.

Verification (col=8, bw=8, pr=8, bw_psum=19)
REQ-029 SHALL test basic load and unsigned execute: 8 loads, vector j lanes all = j+1; then execute with in all 1, sgn=0, col_en=8'hFF at cycle T -> out_k = 8*(k+1), fifo_wr[k] pulses only at T+k+1.
REQ-030 SHALL test signed and unsigned extremes: weights all 8'h80, execute in all 8'h80 with sgn=1 -> out_k = 131072; the same with sgn=0 and all 8'hFF -> out_k = 520200.
REQ-031 SHALL test the column mask: col_en=8'b1010_1010 on execute -> fifo_wr pulses for columns 1,3,5,7 only; even outs retain their prior values.
REQ-032 SHALL test clear and reload: inst=2'b11, then 3 loads of all-2, then execute in all 1 -> columns 0-2 out = 16, columns 3-7 out = 0; all 8 strobes pulse.
REQ-033 SHALL test streaming: 4 consecutive executes, in lane values 1,2,3,4 -> column k emits 4 consecutive fifo_wr cycles with outputs scaling 1:2:3:4.
REQ-034 SHALL test reset mid-operation: assert reset 2 cycles after execute issue -> out=0, fifo_wr=0 immediately; no pulses after release; a subsequent execute yields 0 (weights cleared).
